// File: rtl/if3_predict_stage.sv
// Third fetch stage: predecodes a bundle of MIPS instructions, merges BPD/NLP/RAS
// predictions, truncates after the first taken slot plus delay slot, and registers it for decode.
module if3_predict_stage #(
  parameter int FETCH_WIDTH = 2,
  parameter int RAS_DEPTH   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [32*FETCH_WIDTH-1:0] in_pc,
  input  logic [32*FETCH_WIDTH-1:0] in_inst,
  input  logic [FETCH_WIDTH-1:0]    in_slot_valid,
  input  logic [FETCH_WIDTH-1:0]    in_nlp_valid,
  input  logic [FETCH_WIDTH-1:0]    in_nlp_taken,
  input  logic [32*FETCH_WIDTH-1:0] in_nlp_target,
  input  logic [2*FETCH_WIDTH-1:0]  in_nlp_bim,
  input  logic [FETCH_WIDTH-1:0]    in_bpd_valid,
  input  logic [FETCH_WIDTH-1:0]    in_bpd_taken,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [32*FETCH_WIDTH-1:0] out_pc,
  output logic [32*FETCH_WIDTH-1:0] out_inst,
  output logic [FETCH_WIDTH-1:0]    out_slot_valid,
  output logic [FETCH_WIDTH-1:0]    out_is_j,
  output logic [FETCH_WIDTH-1:0]    out_is_br,
  output logic [FETCH_WIDTH-1:0]    out_pred_taken,
  output logic [32*FETCH_WIDTH-1:0] out_pred_addr,
  output logic                      redirect,
  output logic [31:0]               redirect_pc,
  output logic                      rescue_ds,
  output logic                      nlp_upd_valid,
  output logic [31:0]               nlp_upd_pc,
  output logic [31:0]               nlp_upd_target,
  output logic [1:0]                nlp_upd_bim,
  output logic                      nlp_upd_take
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [31:0]   ras_mem [RAS_DEPTH];
  logic [PW-1:0] ras_ptr;
  logic [CW-1:0] ras_cnt;
  logic          ras_empty;
  logic [31:0]   ras_top;

  assign ras_empty = (ras_cnt == '0);
  assign ras_top   = ras_mem[ras_ptr];

  logic [FETCH_WIDTH-1:0]    is_j, is_br, jr_class, is_call, is_ret, pred_taken;
  logic [32*FETCH_WIDTH-1:0] pred_addr;

  always_comb begin : decode_c
    logic [31:0] inst, pc, pc4, br_tgt, j_tgt;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt;
    logic        v, jabs, jreg, br, ret, call, rs_hit;
    is_j       = '0;
    is_br      = '0;
    jr_class   = '0;
    is_call    = '0;
    is_ret     = '0;
    pred_taken = '0;
    pred_addr  = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      inst   = in_inst[32*i +: 32];
      pc     = in_pc[32*i +: 32];
      v      = in_slot_valid[i];
      op     = inst[31:26];
      rs     = inst[25:21];
      rt     = inst[20:16];
      fn     = inst[5:0];
      pc4    = pc + 32'd4;
      br_tgt = pc4 + {{14{inst[15]}}, inst[15:0], 2'b00};
      j_tgt  = {pc4[31:28], inst[25:0], 2'b00};
      jabs   = v && (op == 6'd2 || op == 6'd3);
      jreg   = v && (op == 6'd0) && (fn == 6'd8 || fn == 6'd9);
      br     = v && ((op[5:2] == 4'b0001) || ((op == 6'd1) && (rt[3:1] == 3'b000)));
      ret    = v && (op == 6'd0) && (fn == 6'd8) && (rs == 5'd31);
      call   = v && ((op == 6'd3) || ((op == 6'd0) && (fn == 6'd9)) ||
                     ((op == 6'd1) && rt[4] && (rt[3:1] == 3'b000)));
      rs_hit = ret && !ras_empty;

      is_j[i]     = jabs | jreg;
      is_br[i]    = br;
      jr_class[i] = jreg;
      is_call[i]  = call;
      is_ret[i]   = ret;

      if (rs_hit)
        pred_addr[32*i +: 32] = ras_top;
      else if (jreg)
        pred_addr[32*i +: 32] = in_nlp_target[32*i +: 32];
      else if (jabs)
        pred_addr[32*i +: 32] = j_tgt;
      else
        pred_addr[32*i +: 32] = br_tgt;

      if (jabs || rs_hit)
        pred_taken[i] = 1'b1;
      else if (jreg)
        pred_taken[i] = in_nlp_valid[i];
      else if (br)
        pred_taken[i] = in_bpd_valid[i] ? in_bpd_taken[i] : (in_nlp_valid[i] & in_nlp_taken[i]);
      else
        pred_taken[i] = 1'b0;
    end
  end

  logic [FETCH_WIDTH-1:0] keep;
  logic                   red, red_rescue, upd, upd_take, ras_push, ras_pop;
  logic [31:0]            red_pc, upd_pc, upd_tgt, push_val;
  logic [1:0]             upd_bim;

  // Walk slots oldest-first: truncation, first mispredict vs NLP, training source, RAS op.
  always_comb begin : select_c
    logic        past_taken, past_ds, red_found, red_taken, valid_after, nt;
    logic [31:0] pc, pa, ntgt;
    keep        = '0;
    red         = 1'b0;
    red_rescue  = 1'b0;
    red_pc      = '0;
    upd         = 1'b0;
    upd_pc      = '0;
    upd_tgt     = '0;
    upd_bim     = '0;
    upd_take    = 1'b0;
    ras_push    = 1'b0;
    ras_pop     = 1'b0;
    push_val    = '0;
    past_taken  = 1'b0;
    past_ds     = 1'b0;
    red_found   = 1'b0;
    red_taken   = 1'b0;
    valid_after = 1'b0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      pc   = in_pc[32*i +: 32];
      pa   = pred_addr[32*i +: 32];
      ntgt = in_nlp_target[32*i +: 32];
      nt   = in_nlp_valid[i] & in_nlp_taken[i];

      keep[i] = in_slot_valid[i] & ~past_ds;
      if (!past_taken && pred_taken[i]) begin
        ras_push = is_call[i];
        ras_pop  = is_ret[i];
        push_val = pc + 32'd8;
      end
      past_ds    = past_ds | past_taken;
      past_taken = past_taken | pred_taken[i];

      if (red_found && in_slot_valid[i])
        valid_after = 1'b1;
      if (!red_found && in_slot_valid[i] &&
          ((pred_taken[i] ^ nt) || (pred_taken[i] && nt && (pa != ntgt)))) begin
        red_found = 1'b1;
        red_taken = pred_taken[i];
        red_pc    = pred_taken[i] ? pa : pc + 32'd8;
      end

      if (!upd && in_slot_valid[i] &&
          (in_bpd_valid[i] || (is_j[i] && (!jr_class[i] || in_nlp_valid[i])))) begin
        upd      = 1'b1;
        upd_pc   = pc;
        upd_tgt  = pa;
        upd_bim  = in_nlp_valid[i] ? in_nlp_bim[2*i +: 2] : 2'b01;
        upd_take = pred_taken[i];
      end
    end
    red        = red_found;
    red_rescue = red_found & red_taken & ~valid_after;
  end

  logic accept;
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Pipeline register; redirect and training pulses drop after the bundle's first cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_pc         <= '0;
      out_inst       <= '0;
      out_slot_valid <= '0;
      out_is_j       <= '0;
      out_is_br      <= '0;
      out_pred_taken <= '0;
      out_pred_addr  <= '0;
      redirect       <= 1'b0;
      redirect_pc    <= '0;
      rescue_ds      <= 1'b0;
      nlp_upd_valid  <= 1'b0;
      nlp_upd_pc     <= '0;
      nlp_upd_target <= '0;
      nlp_upd_bim    <= '0;
      nlp_upd_take   <= 1'b0;
    end else if (flush) begin
      out_valid     <= 1'b0;
      redirect      <= 1'b0;
      nlp_upd_valid <= 1'b0;
    end else if (in_ready) begin
      out_valid     <= in_valid;
      redirect      <= in_valid & red;
      nlp_upd_valid <= in_valid & upd;
      if (in_valid) begin
        out_pc         <= in_pc;
        out_inst       <= in_inst;
        out_slot_valid <= keep;
        out_is_j       <= is_j;
        out_is_br      <= is_br;
        out_pred_taken <= pred_taken;
        out_pred_addr  <= pred_addr;
        redirect_pc    <= red_pc;
        rescue_ds      <= red_rescue;
        nlp_upd_pc     <= upd_pc;
        nlp_upd_target <= upd_tgt;
        nlp_upd_bim    <= upd_bim;
        nlp_upd_take   <= upd_take;
      end
    end else begin
      redirect      <= 1'b0;
      nlp_upd_valid <= 1'b0;
    end
  end

  // A push on a full stack wraps over the oldest entry while the count saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (flush) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (accept) begin
      if (ras_push) begin
        ras_ptr <= ras_ptr + PW'(1);
        if (ras_cnt != CW'(RAS_DEPTH))
          ras_cnt <= ras_cnt + CW'(1);
      end else if (ras_pop && !ras_empty) begin
        ras_ptr <= ras_ptr - PW'(1);
        ras_cnt <= ras_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !flush && ras_push)
      ras_mem[ras_ptr + PW'(1)] <= push_val;
  end

endmodule

// File: tb/tb_if3_predict_stage.sv
// Randomized and directed bench for if3_predict_stage against a queue-based
// behavioural model of prediction, truncation, redirect and return-address stack.
module tb_if3_predict_stage;

  localparam int FW = 2;
  localparam int RD = 8;

  logic            clk = 1'b0;
  logic            rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [32*FW-1:0] in_pc, in_inst, in_nlp_target;
  logic [FW-1:0]   in_slot_valid, in_nlp_valid, in_nlp_taken, in_bpd_valid, in_bpd_taken;
  logic [2*FW-1:0] in_nlp_bim;
  logic [32*FW-1:0] out_pc, out_inst, out_pred_addr;
  logic [FW-1:0]   out_slot_valid, out_is_j, out_is_br, out_pred_taken;
  logic            redirect, rescue_ds, nlp_upd_valid, nlp_upd_take;
  logic [31:0]     redirect_pc, nlp_upd_pc, nlp_upd_target;
  logic [1:0]      nlp_upd_bim;

  if3_predict_stage #(.FETCH_WIDTH(FW), .RAS_DEPTH(RD)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_slot_valid(in_slot_valid),
    .in_nlp_valid(in_nlp_valid), .in_nlp_taken(in_nlp_taken), .in_nlp_target(in_nlp_target),
    .in_nlp_bim(in_nlp_bim), .in_bpd_valid(in_bpd_valid), .in_bpd_taken(in_bpd_taken),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_slot_valid(out_slot_valid), .out_is_j(out_is_j), .out_is_br(out_is_br),
    .out_pred_taken(out_pred_taken), .out_pred_addr(out_pred_addr),
    .redirect(redirect), .redirect_pc(redirect_pc), .rescue_ds(rescue_ds),
    .nlp_upd_valid(nlp_upd_valid), .nlp_upd_pc(nlp_upd_pc), .nlp_upd_target(nlp_upd_target),
    .nlp_upd_bim(nlp_upd_bim), .nlp_upd_take(nlp_upd_take)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: expected register contents and the RAS as a plain queue (top at the back).
  logic [31:0]   ras_q [$];
  logic          m_valid, m_redirect, m_upd_valid, m_rescue, m_upd_take;
  logic [32*FW-1:0] m_pc, m_inst;
  logic [FW-1:0] m_sv, m_isj, m_isbr, m_pt, m_ctl;
  logic [31:0]   m_pa [FW];
  logic [31:0]   m_rpc, m_upd_pc, m_upd_tgt;
  logic [1:0]    m_upd_bim;

  logic          p_red, p_rescue, p_upd, p_upd_take, p_push, p_pop;
  logic [FW-1:0] p_sv, p_isj, p_isbr, p_pt, p_ctl;
  logic [31:0]   p_pa [FW];
  logic [31:0]   p_rpc, p_upd_pc, p_upd_tgt, p_push_val;
  logic [1:0]    p_upd_bim;

  localparam logic [31:0] ALU   = {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};
  localparam logic [31:0] JR31  = {6'd0, 5'd31, 15'd0, 6'd8};

  task automatic checkOutput(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    ras_q.delete();
    m_valid = 0; m_redirect = 0; m_upd_valid = 0;
  endtask

  // Prediction rules evaluated with plain arithmetic on the current inputs and RAS queue.
  task automatic predictBundle();
    int k, s, last, op, fn, rs, rt, simm;
    logic [31:0] pc, w, ntgt, bt, jt;
    logic v, jabs, jreg, br, isret, iscall, nt, nv;
    k = -1; s = -1; last = -1;
    p_upd = 0; p_push = 0; p_pop = 0; p_push_val = 0;
    p_upd_pc = 0; p_upd_tgt = 0; p_upd_bim = 0; p_upd_take = 0;
    p_rpc = 0; p_rescue = 0;
    for (int i = 0; i < FW; i++) begin
      pc = in_pc[32*i +: 32]; w = in_inst[32*i +: 32]; ntgt = in_nlp_target[32*i +: 32];
      v = in_slot_valid[i]; nv = in_nlp_valid[i]; nt = nv && in_nlp_taken[i];
      op = int'(w[31:26]); fn = int'(w[5:0]); rs = int'(w[25:21]); rt = int'(w[20:16]);
      simm = int'($signed(w[15:0]));
      bt = pc + 32'd4 + 32'(simm * 4);
      jt = ((pc + 32'd4) & 32'hF000_0000) | (32'(w[25:0]) << 2);
      jabs   = v && (op == 2 || op == 3);
      jreg   = v && op == 0 && (fn == 8 || fn == 9);
      br     = v && ((op >= 4 && op <= 7) || (op == 1 && (rt == 0 || rt == 1 || rt == 16 || rt == 17)));
      isret  = v && op == 0 && fn == 8 && rs == 31;
      iscall = v && (op == 3 || (op == 0 && fn == 9) || (op == 1 && (rt == 16 || rt == 17)));
      p_isj[i] = jabs || jreg; p_isbr[i] = br; p_ctl[i] = jabs || jreg || br;
      if (isret && ras_q.size() > 0)      p_pa[i] = ras_q[$];
      else if (jreg)                      p_pa[i] = ntgt;
      else if (jabs)                      p_pa[i] = jt;
      else                                p_pa[i] = bt;
      if (jabs || (isret && ras_q.size() > 0)) p_pt[i] = 1;
      else if (jreg)                      p_pt[i] = nv;
      else if (br)                        p_pt[i] = in_bpd_valid[i] ? in_bpd_taken[i] : nt;
      else                                p_pt[i] = 0;
      if (v) last = i;
      if (k < 0 && p_pt[i]) begin
        k = i; p_push = iscall; p_pop = isret; p_push_val = pc + 32'd8;
      end
      if (s < 0 && v && ((p_pt[i] != nt) || (p_pt[i] && nt && p_pa[i] != ntgt))) s = i;
      if (!p_upd && v && (in_bpd_valid[i] || ((jabs || jreg) && (!jreg || nv)))) begin
        p_upd = 1; p_upd_pc = pc; p_upd_tgt = p_pa[i]; p_upd_take = p_pt[i];
        p_upd_bim = nv ? in_nlp_bim[2*i +: 2] : 2'b01;
      end
    end
    for (int i = 0; i < FW; i++) p_sv[i] = in_slot_valid[i] && (k < 0 || i <= k + 1);
    p_red = (s >= 0);
    if (p_red) begin
      p_rpc    = p_pt[s] ? p_pa[s] : in_pc[32*s +: 32] + 32'd8;
      p_rescue = p_pt[s] && (s == last);
    end
  endtask

  task automatic compareAll();
    checkOutput("out_valid", out_valid, m_valid);
    checkOutput("redirect", redirect, m_redirect);
    checkOutput("nlp_upd_valid", nlp_upd_valid, m_upd_valid);
    if (m_valid) begin
      checkOutput("out_pc", out_pc, m_pc);
      checkOutput("out_inst", out_inst, m_inst);
      checkOutput("out_slot_valid", out_slot_valid, m_sv);
      checkOutput("out_is_j", out_is_j, m_isj);
      checkOutput("out_is_br", out_is_br, m_isbr);
      checkOutput("out_pred_taken", out_pred_taken, m_pt);
      for (int i = 0; i < FW; i++)
        if (m_ctl[i]) checkOutput("out_pred_addr", out_pred_addr[32*i +: 32], m_pa[i]);
    end
    if (m_redirect) begin
      checkOutput("redirect_pc", redirect_pc, m_rpc);
      checkOutput("rescue_ds", rescue_ds, m_rescue);
    end
    if (m_upd_valid) begin
      checkOutput("nlp_upd_pc", nlp_upd_pc, m_upd_pc);
      checkOutput("nlp_upd_target", nlp_upd_target, m_upd_tgt);
      checkOutput("nlp_upd_bim", nlp_upd_bim, m_upd_bim);
      checkOutput("nlp_upd_take", nlp_upd_take, m_upd_take);
    end
  endtask

  // Called at a falling edge with inputs driven; returns at the next falling edge.
  task automatic applyStimulus(input logic iv, input logic ordy, input logic fl);
    in_valid = iv; out_ready = ordy; flush = fl;
    #1;
    checkOutput("in_ready", in_ready, !m_valid || out_ready);
    predictBundle();
    @(posedge clk);
    if (flush) begin
      m_valid = 0; m_redirect = 0; m_upd_valid = 0; ras_q.delete();
    end else if (!m_valid || out_ready) begin
      m_valid = in_valid; m_redirect = in_valid && p_red; m_upd_valid = in_valid && p_upd;
      if (in_valid) begin
        m_pc = in_pc; m_inst = in_inst; m_sv = p_sv; m_isj = p_isj; m_isbr = p_isbr;
        m_pt = p_pt; m_ctl = p_ctl; m_pa = p_pa; m_rpc = p_rpc; m_rescue = p_rescue;
        m_upd_pc = p_upd_pc; m_upd_tgt = p_upd_tgt; m_upd_bim = p_upd_bim; m_upd_take = p_upd_take;
        if (p_push) begin
          ras_q.push_back(p_push_val);
          if (ras_q.size() > RD) void'(ras_q.pop_front());
        end else if (p_pop && ras_q.size() > 0) begin
          void'(ras_q.pop_back());
        end
      end
    end else begin
      m_redirect = 0; m_upd_valid = 0;
    end
    #1;
    compareAll();
    @(negedge clk);
  endtask

  task automatic clearSlots();
    in_pc = '0; in_inst = '0; in_slot_valid = '0; in_nlp_valid = '0; in_nlp_taken = '0;
    in_nlp_target = '0; in_nlp_bim = '0; in_bpd_valid = '0; in_bpd_taken = '0;
  endtask

  task automatic setSlot(input int i, input logic [31:0] pc, input logic [31:0] inst,
                         input logic nv, input logic nt, input logic [31:0] ntgt,
                         input logic [1:0] bim, input logic bv, input logic bt);
    in_pc[32*i +: 32] = pc; in_inst[32*i +: 32] = inst; in_slot_valid[i] = 1'b1;
    in_nlp_valid[i] = nv; in_nlp_taken[i] = nt; in_nlp_target[32*i +: 32] = ntgt;
    in_nlp_bim[2*i +: 2] = bim; in_bpd_valid[i] = bv; in_bpd_taken[i] = bt;
  endtask

  function automatic logic [31:0] randInst();
    logic [4:0]  rs, rt;
    logic [15:0] imm;
    int sel;
    rs  = 5'($urandom);
    rt  = 5'($urandom);
    imm = 16'($urandom_range(0, 63)) - 16'd32;
    case ($urandom_range(0, 11))
      2:       return {6'd4, rs, rt, imm};
      3:       return {6'($urandom_range(5, 7)), rs, rt, imm};
      4: begin
        sel = $urandom_range(0, 4);
        rt  = (sel == 0) ? 5'd0 : (sel == 1) ? 5'd1 : (sel == 2) ? 5'd16 : (sel == 3) ? 5'd17 : 5'd2;
        return {6'd1, rs, rt, imm};
      end
      5, 6:    return {6'd3, 26'($urandom)};
      7:       return {6'd2, 26'($urandom)};
      8, 9:    return JR31;
      10:      return {6'd0, rs, 15'd0, 6'd8};
      11:      return {6'd0, rs, 5'd0, 5'd31, 5'd0, 6'd9};
      default: return {6'd0, rs, rt, 5'd3, 5'd0, 6'h21};
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; flush = 0; in_valid = 0; out_ready = 0;
    clearSlots();
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_redirect", redirect, 0);
    checkOutput("reset_upd_valid", nlp_upd_valid, 0);
    checkOutput("reset_out_pc", out_pc, 0);
    checkOutput("reset_redirect_pc", redirect_pc, 0);
    rst_n = 1'b1;

    $display("[TB] BEQ taken by BPD with NLP miss");
    clearSlots();
    setSlot(0, 32'h1000, {6'd4, 5'd1, 5'd2, 16'd4}, 0, 0, 0, 2'b11, 1, 1);
    setSlot(1, 32'h1004, ALU, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0);
    checkOutput("t1_redirect", redirect, 1);
    checkOutput("t1_redirect_pc", redirect_pc, 32'h1014);
    checkOutput("t1_rescue", rescue_ds, 0);
    checkOutput("t1_upd_pc", nlp_upd_pc, 32'h1000);
    checkOutput("t1_upd_take", nlp_upd_take, 1);
    checkOutput("t1_upd_bim", nlp_upd_bim, 2'b01);

    $display("[TB] JAL in last slot, then return");
    clearSlots();
    setSlot(0, 32'h2000, ALU, 0, 0, 0, 0, 0, 0);
    setSlot(1, 32'h2004, {6'd3, 26'h0000800}, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0);
    checkOutput("t2_redirect_pc", redirect_pc, 32'h2000);
    checkOutput("t2_rescue", rescue_ds, 1);
    clearSlots();
    setSlot(0, 32'h2000, JR31, 0, 0, 0, 0, 0, 0);
    setSlot(1, 32'h2004, ALU, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0);
    checkOutput("t2_ret_taken", out_pred_taken[0], 1);
    checkOutput("t2_ret_addr", out_pred_addr[31:0], 32'h200C);

    $display("[TB] RAS overflow with nine calls and nine returns");
    for (int n = 0; n < 9; n++) begin
      clearSlots();
      setSlot(0, 32'h6000 + 32'(16 * n), {6'd3, 26'h0001000}, 0, 0, 0, 0, 0, 0);
      setSlot(1, 32'h6004 + 32'(16 * n), ALU, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 1, 0);
    end
    for (int j = 0; j < 9; j++) begin
      clearSlots();
      setSlot(0, 32'h7000 + 32'(16 * j), JR31, 0, 0, 0, 0, 0, 0);
      setSlot(1, 32'h7004 + 32'(16 * j), ALU, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 1, 0);
      checkOutput("t3_ret_taken", out_pred_taken[0], (j < 8) ? 1 : 0);
      if (j < 8) checkOutput("t3_ret_addr", out_pred_addr[31:0], 32'h6008 + 32'(16 * (8 - j)));
    end

    $display("[TB] NLP taken overridden by BPD not-taken");
    clearSlots();
    setSlot(0, 32'h1008, {6'd5, 5'd1, 5'd2, 16'd8}, 1, 1, 32'h3000, 2'b10, 1, 0);
    setSlot(1, 32'h100C, ALU, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0);
    checkOutput("t4_redirect_pc", redirect_pc, 32'h1010);
    checkOutput("t4_slot_valid", out_slot_valid, 2'b11);

    $display("[TB] Stall with a waiting call bundle");
    clearSlots();
    setSlot(0, 32'h1000, {6'd4, 5'd1, 5'd2, 16'd4}, 0, 0, 0, 0, 1, 1);
    applyStimulus(1, 1, 0);
    clearSlots();
    setSlot(0, 32'h8000, {6'd3, 26'h0002000}, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1, 0, 0);
      checkOutput("t5_stall_redirect", redirect, 0);
      checkOutput("t5_stall_valid", out_valid, 1);
    end

    $display("[TB] Asynchronous reset during stall");
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("t7_out_valid", out_valid, 0);
    checkOutput("t7_out_pc", out_pc, 0);
    checkOutput("t7_out_slot_valid", out_slot_valid, 0);
    checkOutput("t7_redirect_pc", redirect_pc, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] Flush with a call bundle");
    clearSlots();
    setSlot(0, 32'h4000, {6'd3, 26'h0003000}, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0);
    clearSlots();
    setSlot(0, 32'h5000, {6'd3, 26'h0003000}, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1);
    checkOutput("t6_out_valid", out_valid, 0);
    clearSlots();
    setSlot(0, 32'h5100, JR31, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0);
    checkOutput("t6_ras_empty", out_pred_taken[0], 0);

    $display("[TB] Randomized traffic");
    for (int c = 0; c < 600; c++) begin
      logic [31:0] base;
      int r;
      clearSlots();
      base = 32'($urandom) & 32'hFFFF_FFFC;
      for (int i = 0; i < FW; i++)
        setSlot(i, base + 32'(4 * i), randInst(), 1'($urandom), 1'($urandom),
                32'($urandom) & 32'hFFFF_FFFC, 2'($urandom), 1'($urandom), 1'($urandom));
      r = $urandom_range(0, 9);
      if (r == 0) in_slot_valid = 2'b01;
      else if (r == 1) in_slot_valid = 2'b10;
      else if (r == 2) in_slot_valid = 2'b00;
      applyStimulus(($urandom_range(0, 9) < 8), ($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
